// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 VGA timing constants and small helpers. The drawing
// controllers import this package as well so that wall and ceiling bounds
// track the same visible window that vga_timing_gen decodes.
//
// Contents:
//   CNT_W              width of the horizontal / vertical counters
//   VGA_H_* / VGA_V_*  default line and frame timing (pixels / lines)
//   PIX_DIV_W          width of the pixel-enable divider
//   cnt_t              counter type
//   rgb_t              packed {R,G,B} 4:4:4 pixel
//   in_window()        half-open range test lo <= v < hi
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 12;

  // Horizontal timing, in pixel clocks.
  localparam int unsigned VGA_H_TOTAL      = 800;
  localparam int unsigned VGA_H_SYNC       = 96;
  localparam int unsigned VGA_H_DISP_START = 144;
  localparam int unsigned VGA_H_DISP_END   = 784;

  // Vertical timing, in lines.
  localparam int unsigned VGA_V_TOTAL      = 525;
  localparam int unsigned VGA_V_SYNC       = 2;
  localparam int unsigned VGA_V_DISP_START = 35;
  localparam int unsigned VGA_V_DISP_END   = 515;

  // The 100 MHz system clock is divided by 4 to get the 25 MHz pixel rate.
  localparam int unsigned PIX_DIV_W = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Half-open interval membership, matching how the display window is
  // specified (start is visible, end is the first non-visible position).
  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en_div.sv
// ---------------------------------------------------------------------------
// pix_en_div
// Free-running 2-bit divider producing a one-clk pixel strobe every fourth
// clock (when the divider reads 3). Only compiled when the macro
// VGA_PIXEL_DIV4_EN is defined; otherwise vga_timing_gen ties pix_en high.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset, clears the divider
//   pix_en  out  one-clk strobe, high while the divider equals 3
// ---------------------------------------------------------------------------
`ifdef VGA_PIXEL_DIV4_EN
module pix_en_div
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam logic [PIX_DIV_W-1:0] DIV_ONE  = PIX_DIV_W'(1);
  localparam logic [PIX_DIV_W-1:0] DIV_LAST = '1;

  logic [PIX_DIV_W-1:0] div_q;

  // Wraps 3 -> 0 naturally through the 2-bit add. Cleared to 0 by reset so
  // the first strobe lands on the 4th clock after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_ONE;
    end
  end

  assign pix_en = (div_q == DIV_LAST);

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480 VGA timing generator: pixel/line counters, active-low syncs,
// visible-area decode, end-of-frame tick and RGB blanking to the DAC.
//
// Optional feature macro: VGA_PIXEL_DIV4_EN
//   defined   : pix_en comes from pix_en_div (one clk in four), a frame is
//               1,680,000 clk.
//   undefined : pix_en is tied high, a frame is 420,000 clk (simulation and
//               fast-clock builds).
//
// Ports:
//   clk         in   system clock (100 MHz)
//   rst         in   synchronous active-high reset
//   rgb_in      in   {R[3:0],G[3:0],B[3:0]} from the drawing logic
//   hCount      out  horizontal pixel counter, 0..H_TOTAL-1
//   vCount      out  vertical line counter, 0..V_TOTAL-1
//   bright      out  high inside the visible area
//   hSync       out  horizontal sync, active low
//   vSync       out  vertical sync, active low
//   pix_en      out  one-clk pixel strobe
//   frame_tick  out  one-clk pulse on the last pixel strobe of a frame
//   vgaR/G/B    out  colour to the DAC, zero outside the visible area
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
  parameter int unsigned H_SYNC       = VGA_H_SYNC,
  parameter int unsigned H_DISP_START = VGA_H_DISP_START,
  parameter int unsigned H_DISP_END   = VGA_H_DISP_END,
  parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
  parameter int unsigned V_SYNC       = VGA_V_SYNC,
  parameter int unsigned V_DISP_START = VGA_V_DISP_START,
  parameter int unsigned V_DISP_END   = VGA_V_DISP_END
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             hSync,
  output logic             vSync,
  output logic             pix_en,
  output logic             frame_tick,
  output logic [3:0]       vgaR,
  output logic [3:0]       vgaG,
  output logic [3:0]       vgaB
);

  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYNC_C = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_C = cnt_t'(V_SYNC);
  localparam cnt_t H_VIS_LO = cnt_t'(H_DISP_START);
  localparam cnt_t H_VIS_HI = cnt_t'(H_DISP_END);
  localparam cnt_t V_VIS_LO = cnt_t'(V_DISP_START);
  localparam cnt_t V_VIS_HI = cnt_t'(V_DISP_END);

  logic h_wrap;
  logic v_wrap;
  logic h_vis;
  logic v_vis;
  rgb_t pix;

  // Pixel strobe source
`ifdef VGA_PIXEL_DIV4_EN
  pix_en_div u_pix_en_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );
`else
  assign pix_en = 1'b1;
`endif

  // Wrap on ">=" rather than "==" so a counter can never run past its last
  // legal value, whatever state it starts in.
  assign h_wrap = (hCount >= H_LAST);
  assign v_wrap = (vCount >= V_LAST);

  // Counter stage
  always_ff @(posedge clk) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hCount <= '0;
        vCount <= v_wrap ? '0 : (vCount + CNT_ONE);
      end else begin
        hCount <= hCount + CNT_ONE;
      end
    end
  end

  // Zero-latency decode of the registered counters
  assign hSync = (hCount >= H_SYNC_C);
  assign vSync = (vCount >= V_SYNC_C);

  assign h_vis  = in_window(hCount, H_VIS_LO, H_VIS_HI);
  assign v_vis  = in_window(vCount, V_VIS_LO, V_VIS_HI);
  assign bright = h_vis && v_vis;

  // Fires on the strobe that moves the counters from the last pixel of the
  // last line back to (0,0).
  assign frame_tick = pix_en && (hCount == H_LAST) && (vCount == V_LAST);

  assign pix  = rgb_t'(rgb_in);
  assign vgaR = bright ? pix.r : 4'h0;
  assign vgaG = bright ? pix.g : 4'h0;
  assign vgaB = bright ? pix.b : 4'h0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

`ifdef VGA_PIXEL_DIV4_EN
  localparam int P = 4;
  localparam longint FRAME_CLK = 1680000;
`else
  localparam int P = 1;
  localparam longint FRAME_CLK = 420000;
`endif
  localparam int HT = 800;
  localparam int VT = 525;
  localparam longint FRAME_PIX = HT * VT;
  localparam int FAIL_CAP = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rgb_in = 12'h000;
  logic [9:0]  hCount, vCount;
  logic        bright, hSync, vSync, pix_en, frame_tick;
  logic [3:0]  vgaR, vgaG, vgaB;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint t       = 0;   // clock edges since reset release
  longint t_tick1 = 0;
  bit     rand_rgb = 1'b1;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in),
    .hCount(hCount), .vCount(vCount), .bright(bright),
    .hSync(hSync), .vSync(vSync), .pix_en(pix_en), .frame_tick(frame_tick),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  always #5 clk = ~clk;

  // Reference model: after tt edges, tt/P pixel strobes have been taken; the
  // raster position is that count modulo the frame size.
  function automatic int m_h(input longint tt);
    longint pos;
    pos = (tt / P) % FRAME_PIX;
    return int'(pos % HT);
  endfunction

  function automatic int m_v(input longint tt);
    longint pos;
    pos = (tt / P) % FRAME_PIX;
    return int'(pos / HT);
  endfunction

  // A strobe is present in the cycle leading up to every P-th edge.
  function automatic logic m_pe(input longint tt);
    return ((tt + 1) % P) == 0;
  endfunction

  function automatic logic m_bright(input int h, input int v);
    return (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
  endfunction

  // Advance one clock; leaves time 1 unit after the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) t = 0; else t++;
    @(negedge clk);
    if (rand_rgb) rgb_in = 12'($urandom);
    #1;
  endtask

  task automatic test_reset();
    rgb_in = 12'hFFF;
    rand_rgb = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    n_tests++; if (hCount !== 10'd0) begin n_fail++; $display("FAIL reset_h got %0d want 0", hCount); end
    n_tests++; if (vCount !== 10'd0) begin n_fail++; $display("FAIL reset_v got %0d want 0", vCount); end
    n_tests++; if (hSync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync got %b want 0", hSync); end
    n_tests++; if (vSync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync got %b want 0", vSync); end
    n_tests++; if (bright !== 1'b0) begin n_fail++; $display("FAIL reset_bright got %b want 0", bright); end
    n_tests++; if (pix_en !== (P == 1)) begin n_fail++; $display("FAIL reset_pix_en got %b want %b", pix_en, (P == 1)); end
    n_tests++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
    n_tests++; if ({vgaR, vgaG, vgaB} !== 12'h000) begin n_fail++; $display("FAIL reset_vga got %h want 000", {vgaR, vgaG, vgaB}); end
  endtask

  task automatic test_startup();
    rst = 1'b0;
    rand_rgb = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      n_tests++;
      if (pix_en !== ((k % P) == 0)) begin
        n_fail++; $display("FAIL startup_pix_en clk %0d got %b want %b", k, pix_en, ((k % P) == 0));
      end
      step();
    end
    n_tests++; if (hCount !== 10'(12 / P)) begin n_fail++; $display("FAIL startup_h got %0d want %0d", hCount, 12 / P); end
    n_tests++; if (vCount !== 10'd0) begin n_fail++; $display("FAIL startup_v got %0d want 0", vCount); end
  endtask

  task automatic test_line_wrap();
    while (!(m_h(t) == 799 && m_v(t) == 10 && m_pe(t))) begin
      step();
      n_tests++;
      if (hCount !== 10'(m_h(t)) || vCount !== 10'(m_v(t))) begin
        n_fail++; $display("FAIL line_wrap_track got (%0d,%0d) want (%0d,%0d)", hCount, vCount, m_h(t), m_v(t));
        if (n_fail > FAIL_CAP) return;
      end
    end
    step();
    n_tests++; if (hCount !== 10'd0) begin n_fail++; $display("FAIL line_wrap_h got %0d want 0", hCount); end
    n_tests++; if (vCount !== 10'd11) begin n_fail++; $display("FAIL line_wrap_v got %0d want 11", vCount); end
  endtask

  task automatic test_bright_sweep();
    int rise_h = -1;
    int fall_h = -1;
    logic prev = 1'b0;
    while (!(m_v(t) == 35 && m_h(t) == 0)) step();
    prev = bright;
    while (m_v(t) == 35) begin
      n_tests++;
      if (bright !== m_bright(m_h(t), 35)) begin
        n_fail++; $display("FAIL sweep_bright h %0d got %b want %b", m_h(t), bright, m_bright(m_h(t), 35));
        if (n_fail > FAIL_CAP) return;
      end
      n_tests++;
      if ({vgaR, vgaG, vgaB} !== (m_bright(m_h(t), 35) ? rgb_in : 12'h000)) begin
        n_fail++; $display("FAIL sweep_vga h %0d got %h rgb_in %h", m_h(t), {vgaR, vgaG, vgaB}, rgb_in);
        if (n_fail > FAIL_CAP) return;
      end
      step();
      if (bright === 1'b1 && prev !== 1'b1 && rise_h < 0) rise_h = int'(hCount);
      if (bright !== 1'b1 && prev === 1'b1 && fall_h < 0) fall_h = int'(hCount);
      prev = bright;
    end
    n_tests++; if (rise_h !== 144) begin n_fail++; $display("FAIL sweep_rise got %0d want 144", rise_h); end
    n_tests++; if (fall_h !== 784) begin n_fail++; $display("FAIL sweep_fall got %0d want 784", fall_h); end
  endtask

  task automatic test_rgb();
    while (!(m_v(t) == 100 && m_h(t) == 100)) step();
    rand_rgb = 1'b0;
    rgb_in = 12'hF0F;
    #1;
    n_tests++; if ({vgaR, vgaG, vgaB} !== 12'h000) begin n_fail++; $display("FAIL rgb_blank got %h want 000", {vgaR, vgaG, vgaB}); end
    while (!(m_v(t) == 100 && m_h(t) == 200)) step();
    n_tests++; if (vgaR !== 4'hF) begin n_fail++; $display("FAIL rgb_r got %h want F", vgaR); end
    n_tests++; if (vgaG !== 4'h0) begin n_fail++; $display("FAIL rgb_g got %h want 0", vgaG); end
    n_tests++; if (vgaB !== 4'hF) begin n_fail++; $display("FAIL rgb_b got %h want F", vgaB); end
    rand_rgb = 1'b1;
  endtask

  task automatic test_bright_off();
    while (!(m_v(t) == 515 && m_h(t) == 0)) step();
    while (m_v(t) == 515) begin
      n_tests++;
      if (bright !== 1'b0 || {vgaR, vgaG, vgaB} !== 12'h000) begin
        n_fail++; $display("FAIL line515_dark h %0d bright %b vga %h want 0", m_h(t), bright, {vgaR, vgaG, vgaB});
        if (n_fail > FAIL_CAP) return;
      end
      step();
    end
  endtask

  task automatic test_frame_wrap();
    while (!(m_h(t) == 799 && m_v(t) == 524 && m_pe(t))) begin
      n_tests++;
      if (frame_tick !== 1'b0) begin
        n_fail++; $display("FAIL frame_early_tick at (%0d,%0d) got 1 want 0", m_h(t), m_v(t));
        if (n_fail > FAIL_CAP) return;
      end
      step();
    end
    n_tests++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL frame_tick got %b want 1", frame_tick); end
    t_tick1 = t;
    step();
    n_tests++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL frame_tick_width got %b want 0", frame_tick); end
    n_tests++; if (hCount !== 10'd0) begin n_fail++; $display("FAIL frame_wrap_h got %0d want 0", hCount); end
    n_tests++; if (vCount !== 10'd0) begin n_fail++; $display("FAIL frame_wrap_v got %0d want 0", vCount); end
  endtask

  task automatic test_frame_period();
    longint budget = 0;
    longint t_tick2 = -1;
    while (budget < 2 * FRAME_CLK) begin
      int  h;
      int  v;
      logic pe;
      logic br;
      h  = m_h(t);
      v  = m_v(t);
      pe = m_pe(t);
      br = m_bright(h, v);
      n_tests++;
      if (hCount !== 10'(h) || vCount !== 10'(v) || pix_en !== pe ||
          hSync !== (h >= 96) || vSync !== (v >= 2) || bright !== br ||
          frame_tick !== (pe && h == 799 && v == 524) ||
          {vgaR, vgaG, vgaB} !== (br ? rgb_in : 12'h000)) begin
        n_fail++;
        $display("FAIL model t %0d got h%0d v%0d pe%b hs%b vs%b br%b ft%b vga%h want h%0d v%0d pe%b br%b",
                 t, hCount, vCount, pix_en, hSync, vSync, bright, frame_tick, {vgaR, vgaG, vgaB},
                 h, v, pe, br);
        if (n_fail > FAIL_CAP) break;
      end
      if (frame_tick === 1'b1) begin
        t_tick2 = t;
        break;
      end
      step();
      budget++;
    end
    n_tests++;
    if (t_tick2 < 0) begin
      n_fail++; $display("FAIL frame_period no tick within %0d clk", 2 * FRAME_CLK);
    end else if (t_tick2 - t_tick1 !== FRAME_CLK) begin
      n_fail++; $display("FAIL frame_period got %0d want %0d", t_tick2 - t_tick1, FRAME_CLK);
    end
    if (t_tick2 >= 0) step();
  endtask

  task automatic test_mid_reset();
    while (!(m_h(t) == 500 && m_v(t) == 300)) step();
    n_tests++;
    if (hCount !== 10'd500 || vCount !== 10'd300) begin
      n_fail++; $display("FAIL mid_pos got (%0d,%0d) want (500,300)", hCount, vCount);
    end
    rand_rgb = 1'b0;
    rgb_in = 12'hFFF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_tests++; if (hCount !== 10'd0) begin n_fail++; $display("FAIL mid_reset_h got %0d want 0", hCount); end
    n_tests++; if (vCount !== 10'd0) begin n_fail++; $display("FAIL mid_reset_v got %0d want 0", vCount); end
    n_tests++; if (hSync !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hsync got %b want 0", hSync); end
    n_tests++; if (vSync !== 1'b0) begin n_fail++; $display("FAIL mid_reset_vsync got %b want 0", vSync); end
    n_tests++; if (bright !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bright got %b want 0", bright); end
    n_tests++; if ({vgaR, vgaG, vgaB} !== 12'h000) begin n_fail++; $display("FAIL mid_reset_vga got %h want 000", {vgaR, vgaG, vgaB}); end
    step();
    n_tests++; if (hCount !== 10'(1 / P)) begin n_fail++; $display("FAIL mid_restart_h got %0d want %0d", hCount, 1 / P); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line_wrap();
    test_bright_sweep();
    test_rgb();
    test_bright_off();
    test_frame_wrap();
    test_frame_period();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
